// File: rtl/freelist_ckpt_pkg.sv
// rtl/freelist_ckpt_pkg.sv - shared defaults, tag/checkpoint types and mask/count helpers for the free list
package freelist_ckpt_pkg;

  localparam int FL_DEPTH     = 32;
  localparam int FL_READ      = 4;
  localparam int FL_WRITE     = 4;
  localparam int FL_CKPT      = 4;
  localparam int FL_RESV      = 0;
  localparam int FL_MAX_DEPTH = 1024;
  localparam int FL_DATA      = $clog2(FL_DEPTH);
  localparam int FL_CKW       = (FL_CKPT > 1) ? $clog2(FL_CKPT) : 1;

  typedef logic [FL_DATA-1:0]      tag_t;
  typedef logic [FL_CKW-1:0]       ck_id_t;
  typedef logic [FL_MAX_DEPTH-1:0] fl_vec_t;

  // Bits 0..resv-1 set: the permanently mapped architectural tags.
  function automatic fl_vec_t fl_resv_mask(input int resv);
    fl_vec_t m;
    m = '0;
    for (int t = 0; t < FL_MAX_DEPTH; t++) begin
      if (t < resv) m[t] = 1'b1;
    end
    return m;
  endfunction

  // Counts active-low (free) bits among the first depth entries.
  function automatic int fl_count_free(input fl_vec_t used, input int depth);
    int n;
    n = 0;
    for (int t = 0; t < FL_MAX_DEPTH; t++) begin
      if (t < depth && !used[t]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/freelist_ckpt_if.sv
// rtl/freelist_ckpt_if.sv - allocate/release/checkpoint bundle between rename logic and the free list
interface freelist_ckpt_if #(
  parameter int DEPTH = 32,
  parameter int READ  = 4,
  parameter int WRITE = 4,
  parameter int CKPT  = 4
);
  localparam int DATA = $clog2(DEPTH);
  localparam int CW   = DATA + 1;
  localparam int CKW  = (CKPT > 1) ? $clog2(CKPT) : 1;

  logic [WRITE-1:0]           we;
  logic [WRITE-1:0][DATA-1:0] wd;
  logic [READ-1:0]            re;
  logic [READ-1:0][DATA-1:0]  rd;
  logic [READ-1:0]            v;
  logic                       empty;
  logic [CW-1:0]              free_cnt;
  logic                       ck_save;
  logic [CKW-1:0]             ck_sid;
  logic                       ck_rest;
  logic [CKW-1:0]             ck_rid;
  logic                       ck_rel;
  logic [CKW-1:0]             ck_lid;
  logic [CKPT-1:0]            ck_live;

  modport master (
    output we, wd, re, ck_save, ck_sid, ck_rest, ck_rid, ck_rel, ck_lid,
    input  rd, v, empty, free_cnt, ck_live
  );

  modport slave (
    input  we, wd, re, ck_save, ck_sid, ck_rest, ck_rid, ck_rel, ck_lid,
    output rd, v, empty, free_cnt, ck_live
  );

endinterface

// File: rtl/freelist_ckpt_pick.sv
// rtl/freelist_ckpt_pick.sv - k-th lowest free tag selector, one offer per allocation port
module freelist_ckpt_pick #(
  parameter int DEPTH = 32,
  parameter int READ  = 4,
  parameter int DATA  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]          usage,
  output logic [READ-1:0][DATA-1:0] rd,
  output logic [READ-1:0]           v
);

  always_comb begin
    int seen;
    rd   = '0;
    v    = '0;
    seen = 0;
    for (int t = 0; t < DEPTH; t++) begin
      if (!usage[t]) begin
        for (int k = 0; k < READ; k++) begin
          if (seen == k) begin
            rd[k] = DATA'(t);
            v[k]  = 1'b1;
          end
        end
        seen++;
      end
    end
  end

endmodule

// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - multi-port tag free list with checkpoint/restore of speculative allocations
module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int DEPTH = FL_DEPTH,
  parameter int READ  = FL_READ,
  parameter int WRITE = FL_WRITE,
  parameter int CKPT  = FL_CKPT,
  parameter int RESV  = FL_RESV
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  freelist_ckpt_if.slave bus
);

  localparam int DATA = $clog2(DEPTH);
  localparam int CW   = DATA + 1;
  localparam int CKW  = (CKPT > 1) ? $clog2(CKPT) : 1;
  localparam logic [DEPTH-1:0] RESV_MASK = DEPTH'(fl_resv_mask(RESV));
  localparam logic [CW-1:0]    INIT_CNT  = CW'(DEPTH - RESV);
  localparam logic             INIT_EMPTY = (DEPTH - RESV) < READ;

  logic [DEPTH-1:0]            r_usage;
  logic [CKPT-1:0][DEPTH-1:0]  r_since;
  logic [CKPT-1:0]             r_live;
  logic                        r_empty;
  logic [CW-1:0]               r_free_cnt;

  logic                        rest_ok;
  logic [DEPTH-1:0]            rest_mask;
  logic [DEPTH-1:0]            consumed;
  logic [DEPTH-1:0]            released;
  logic [DEPTH-1:0]            n_usage;
  logic [CKPT-1:0][DEPTH-1:0]  n_since;
  logic [CKPT-1:0]             n_live;
  logic [CW-1:0]               n_cnt;
  logic                        wd_dup;
  logic                        wd_resv;

  freelist_ckpt_pick #(
    .DEPTH(DEPTH),
    .READ (READ),
    .DATA (DATA)
  ) u_pick (
    .usage(r_usage),
    .rd   (bus.rd),
    .v    (bus.v)
  );

  // A restore suppresses every allocation in its cycle so nothing is both reclaimed and handed out.
  always_comb begin
    rest_ok   = bus.ck_rest && r_live[bus.ck_rid];
    rest_mask = rest_ok ? r_since[bus.ck_rid] : '0;
    consumed  = '0;
    released  = '0;
    for (int k = 0; k < READ; k++) begin
      if (!rest_ok && bus.re[k] && bus.v[k]) consumed[bus.rd[k]] = 1'b1;
    end
    // Only tags currently held can be released; freeing a free or reserved tag does nothing.
    for (int w = 0; w < WRITE; w++) begin
      if (bus.we[w] && r_usage[bus.wd[w]] && !RESV_MASK[bus.wd[w]]) released[bus.wd[w]] = 1'b1;
    end
    n_usage = (r_usage & ~released & ~rest_mask) | consumed;
    n_cnt   = CW'(fl_count_free(fl_vec_t'(n_usage), DEPTH));
  end

  // Slot update order: track, then restore clears own mask, then close, then open (save wins).
  always_comb begin
    for (int c = 0; c < CKPT; c++) begin
      n_live[c]  = r_live[c];
      n_since[c] = r_live[c] ? ((r_since[c] & ~rest_mask & ~released) | consumed) : '0;
      if (rest_ok && bus.ck_rid == CKW'(c)) n_since[c] = '0;
      if (bus.ck_rel && bus.ck_lid == CKW'(c)) begin
        n_live[c]  = 1'b0;
        n_since[c] = '0;
      end
      if (bus.ck_save && bus.ck_sid == CKW'(c)) begin
        n_live[c]  = 1'b1;
        n_since[c] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_usage    <= RESV_MASK;
      r_since    <= '0;
      r_live     <= '0;
      r_empty    <= INIT_EMPTY;
      r_free_cnt <= INIT_CNT;
    end else begin
      r_usage    <= n_usage;
      r_since    <= n_since;
      r_live     <= n_live;
      r_empty    <= n_cnt < CW'(READ);
      r_free_cnt <= n_cnt;
    end
  end

  assign bus.empty    = r_empty;
  assign bus.free_cnt = r_free_cnt;
  assign bus.ck_live  = r_live;

  always_comb begin
    wd_dup  = 1'b0;
    wd_resv = 1'b0;
    for (int w = 0; w < WRITE; w++) begin
      if (bus.we[w] && RESV_MASK[bus.wd[w]]) wd_resv = 1'b1;
      for (int x = w + 1; x < WRITE; x++) begin
        if (bus.we[w] && bus.we[x] && bus.wd[w] == bus.wd[x]) wd_dup = 1'b1;
      end
    end
  end

  a_no_dup_release: assert property (@(posedge clk) disable iff (reset || flush) !wd_dup);
  a_no_resv_release: assert property (@(posedge clk) disable iff (reset || flush) !wd_resv);

endmodule

// File: tb/tb_freelist_ckpt.sv
// tb/tb_freelist_ckpt.sv - directed scoreboard bench for freelist_ckpt at DEPTH=8 READ=2 WRITE=2 CKPT=2 RESV=2
module tb_freelist_ckpt;

  localparam int DEPTH = 8;
  localparam int READ  = 2;
  localparam int WRITE = 2;
  localparam int CKPT  = 2;
  localparam int RESV  = 2;

  typedef struct {
    int         cyc;
    int         step;
    int         rd0;
    int         rd1;
    logic [1:0] v;
    logic       empty;
    int         cnt;
    logic [1:0] live;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;
  int   cyc;
  int   checks;
  int   errors;
  int   step_no;
  exp_t exp_q[$];

  freelist_ckpt_if #(.DEPTH(DEPTH), .READ(READ), .WRITE(WRITE), .CKPT(CKPT)) bus ();

  freelist_ckpt #(
    .DEPTH(DEPTH),
    .READ (READ),
    .WRITE(WRITE),
    .CKPT (CKPT),
    .RESV (RESV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int step, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL step%0d %s: got %0d expected %0d", step, name, got, want);
    end
  endtask

  // Monitor: compares the DUT offer/status against the entry queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL step%0d missed: got cycle %0d expected cycle %0d", exp_q[0].step, cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd0", e.step, int'(bus.rd[0]), e.rd0);
      chk("rd1", e.step, int'(bus.rd[1]), e.rd1);
      chk("v", e.step, int'(bus.v), int'(e.v));
      chk("empty", e.step, int'(bus.empty), int'(e.empty));
      chk("free_cnt", e.step, int'(bus.free_cnt), e.cnt);
      chk("ck_live", e.step, int'(bus.ck_live), int'(e.live));
    end
  end

  // One cycle of stimulus plus the outputs expected while it is applied (state before the edge).
  task automatic drv(input logic [1:0] re, input logic [1:0] we, input int wd0, input int wd1,
                     input logic sv, input int sid, input logic rs, input int rid,
                     input logic rl, input int lid, input logic fl,
                     input int e_rd0, input int e_rd1, input logic [1:0] e_v,
                     input logic e_empty, input int e_cnt, input logic [1:0] e_live);
    exp_t e;
    bus.re      = re;
    bus.we      = we;
    bus.wd[0]   = 3'(wd0);
    bus.wd[1]   = 3'(wd1);
    bus.ck_save = sv;
    bus.ck_sid  = 1'(sid);
    bus.ck_rest = rs;
    bus.ck_rid  = 1'(rid);
    bus.ck_rel  = rl;
    bus.ck_lid  = 1'(lid);
    flush       = fl;
    e.cyc   = cyc;
    e.step  = step_no;
    e.rd0   = e_rd0;
    e.rd1   = e_rd1;
    e.v     = e_v;
    e.empty = e_empty;
    e.cnt   = e_cnt;
    e.live  = e_live;
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    reset   = 1'b1;
    flush   = 1'b0;
    bus.re = '0; bus.we = '0; bus.wd = '0;
    bus.ck_save = 1'b0; bus.ck_sid = '0; bus.ck_rest = 1'b0; bus.ck_rid = '0;
    bus.ck_rel = 1'b0; bus.ck_lid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    //   re     we     wd0 wd1 sv sid rs rid rl lid fl  rd0 rd1 v      emp cnt live
    // drain all six tags, then offers go invalid
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 2'b11, 0, 6, 2'b00);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b00);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   6, 7, 2'b11, 0, 2, 2'b00);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2'b00, 1, 0, 2'b00);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2'b00, 1, 0, 2'b00);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 2'b00, 1, 0, 2'b00);
    // allocate 2,3 then release 2 while consuming 4
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 2'b11, 0, 6, 2'b00);
    drv(2'b01, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b00);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 5, 2'b11, 0, 4, 2'b00);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 5, 2'b11, 0, 4, 2'b00);
    // save with same-cycle allocation, allocate more, restore (with re ignored)
    drv(2'b11, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 3, 2'b11, 0, 6, 2'b00);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b01);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0,   6, 7, 2'b11, 0, 2, 2'b01);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b01);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b01);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 5, 2'b11, 0, 4, 2'b01);
    // nested checkpoints, release inside, restore outer
    drv(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 3, 2'b11, 0, 6, 2'b00);
    drv(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 2'b11, 0, 6, 2'b01);
    drv(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 0,   3, 4, 2'b11, 0, 5, 2'b01);
    drv(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 4, 2'b11, 0, 5, 2'b11);
    drv(2'b00, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b11);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0,   2, 4, 2'b11, 0, 5, 2'b11);
    // close slot 1 while allocating; save+restore slot 0 together
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0,   2, 3, 2'b11, 0, 6, 2'b11);
    drv(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b01);
    // save beats release on slot 1; save-cycle allocation is not reclaimed by that slot
    drv(2'b01, 2'b00, 0, 0, 1, 1, 0, 0, 1, 1, 0,   2, 3, 2'b11, 0, 6, 2'b01);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0,   3, 4, 2'b11, 0, 5, 2'b11);
    // flush with live checkpoints and concurrent traffic
    drv(2'b11, 2'b01, 2, 0, 1, 0, 1, 1, 0, 0, 1,   3, 4, 2'b11, 0, 5, 2'b11);
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 3, 2'b11, 0, 6, 2'b00);
    // fill to one free tag: empty asserts with a single valid offer
    drv(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 5, 2'b11, 0, 4, 2'b00);
    drv(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   6, 7, 2'b11, 0, 2, 2'b00);
    drv(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   7, 0, 2'b01, 1, 1, 2'b00);
    drv(2'b01, 2'b11, 3, 5, 0, 0, 0, 0, 0, 0, 0,   7, 0, 2'b01, 1, 1, 2'b00);
    // releasing an already-free tag has no effect
    drv(2'b00, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0,   3, 5, 2'b11, 0, 2, 2'b00);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 5, 2'b11, 0, 2, 2'b00);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
